// File: rtl/mem_controller_pkg.sv
// mem_controller_pkg: shared FSM state encoding and grant codes for the memory controller slice.
package mem_controller_pkg;
  typedef enum logic [1:0] {MC_IDLE, MC_ACCESS, MC_RESP} mc_state_t;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/mc_rr_arbiter.sv
// mc_rr_arbiter: 2-way round-robin between I and D requests; owns LastGrant.
module mc_rr_arbiter
  import mem_controller_pkg::*;
(
  input  logic CLK,
  input  logic Reset_L,
  input  logic req_i,
  input  logic req_d,
  input  logic accept,
  output logic grant
);
  logic last_grant;
  assign grant = (req_i && req_d) ? ((last_grant == GNT_D) ? GNT_I : GNT_D)
                                  : (req_d ? GNT_D : GNT_I);
  always_ff @(posedge CLK or negedge Reset_L)
    if (!Reset_L) last_grant <= GNT_D;
    else if (accept) last_grant <= grant;
endmodule

// File: rtl/mem_controller.sv
// mem_controller: arbitrates I/D cache word requests onto a synchronous single-port SRAM
// with a fixed access latency from accept to the DataValid pulse.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                  CLK,
  input  logic                  Reset_L,
  input  logic                  IMemRead,
  input  logic [31:0]           IMemReadAddr,
  output logic                  IDataValid,
  output logic [31:0]           IDataOut,
  input  logic                  DMemRead,
  input  logic                  DMemWrite,
  input  logic [31:0]           DMemAddr,
  input  logic [31:0]           DMemWriteData,
  output logic                  DDataValid,
  output logic [31:0]           DDataOut,
  output logic [MEM_ADDR_W-1:0] MemAddr,
  output logic                  MemRdEn,
  output logic                  MemWrEn,
  output logic [31:0]           MemWrData,
  input  logic [31:0]           MemRdData
);
  mc_state_t             state;
  logic [7:0]            cnt;
  logic                  grant, cap_gnt, cap_wr, accept, strobe, resp;
  logic [MEM_ADDR_W-1:0] cap_addr;
  logic [31:0]           cap_data, rd_data;
  // Address bits outside the SRAM word range alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IMemReadAddr[31:MEM_ADDR_W+2], IMemReadAddr[1:0],
                              DMemAddr[31:MEM_ADDR_W+2], DMemAddr[1:0]};
  assign accept = (state == MC_IDLE) && (IMemRead || DMemRead || DMemWrite);
  mc_rr_arbiter u_arb (
    .CLK(CLK), .Reset_L(Reset_L), .req_i(IMemRead), .req_d(DMemRead || DMemWrite),
    .accept(accept), .grant(grant)
  );
  always_ff @(posedge CLK or negedge Reset_L)
    if (!Reset_L) begin
      state    <= MC_IDLE;
      cnt      <= '0;
      cap_gnt  <= GNT_I;
      cap_wr   <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
    end else if (accept) begin
      state    <= MC_ACCESS;
      cnt      <= 8'(LATENCY - 2);
      cap_gnt  <= grant;
      cap_wr   <= (grant == GNT_D) && DMemWrite;
      cap_addr <= (grant == GNT_D) ? DMemAddr[MEM_ADDR_W+1:2] : IMemReadAddr[MEM_ADDR_W+1:2];
      cap_data <= DMemWriteData;
    end else if (state == MC_ACCESS) begin
      if (cnt == 8'd0) state <= MC_RESP;
      else cnt <= cnt - 8'd1;
    end else if (state == MC_RESP) state <= MC_IDLE;
  // SRAM strobes fire in the last ACCESS cycle so read data lands in RESP.
  assign strobe     = (state == MC_ACCESS) && (cnt == 8'd0);
  assign resp       = (state == MC_RESP);
  assign MemAddr    = strobe ? cap_addr : '0;
  assign MemRdEn    = strobe && !cap_wr;
  assign MemWrEn    = strobe && cap_wr;
  assign MemWrData  = MemWrEn ? cap_data : '0;
  assign rd_data    = (resp && !cap_wr) ? MemRdData : '0;
  assign IDataValid = resp && (cap_gnt == GNT_I);
  assign DDataValid = resp && (cap_gnt == GNT_D);
  assign IDataOut   = IDataValid ? rd_data : '0;
  assign DDataOut   = DDataValid ? rd_data : '0;
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed self-checking bench for mem_controller (LATENCY=3 and LATENCY=2).
module tb_mem_controller;
  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        IMemRead = 1'b0, DMemRead = 1'b0, DMemWrite = 1'b0;
  logic [31:0] IMemReadAddr = '0, DMemAddr = '0, DMemWriteData = '0;
  logic        IDataValid, DDataValid, MemRdEn, MemWrEn;
  logic [31:0] IDataOut, DDataOut, MemWrData, MemRdData;
  logic [15:0] MemAddr;
  logic [31:0] sram [0:65535];
  logic        i2_rd = 1'b0;
  logic [31:0] i2_addr = '0;
  logic        i2_valid, d2_valid, rd2_en, wr2_en;
  logic [31:0] i2_out, d2_out, wr2_data, rd2_data;
  logic [15:0] addr2;
  int checks = 0, failures = 0;
  int rd_cnt = 0, wr_cnt = 0, iv_cnt = 0, dv_cnt = 0;
  always #5 CLK = ~CLK;
  mem_controller #(.LATENCY(3), .MEM_ADDR_W(16)) u_dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .IMemRead(IMemRead), .IMemReadAddr(IMemReadAddr), .IDataValid(IDataValid), .IDataOut(IDataOut),
    .DMemRead(DMemRead), .DMemWrite(DMemWrite), .DMemAddr(DMemAddr), .DMemWriteData(DMemWriteData),
    .DDataValid(DDataValid), .DDataOut(DDataOut),
    .MemAddr(MemAddr), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .MemWrData(MemWrData), .MemRdData(MemRdData)
  );
  mem_controller #(.LATENCY(2), .MEM_ADDR_W(16)) u_dut2 (
    .CLK(CLK), .Reset_L(Reset_L),
    .IMemRead(i2_rd), .IMemReadAddr(i2_addr), .IDataValid(i2_valid), .IDataOut(i2_out),
    .DMemRead(1'b0), .DMemWrite(1'b0), .DMemAddr(32'h0), .DMemWriteData(32'h0),
    .DDataValid(d2_valid), .DDataOut(d2_out),
    .MemAddr(addr2), .MemRdEn(rd2_en), .MemWrEn(wr2_en), .MemWrData(wr2_data), .MemRdData(rd2_data)
  );
  always @(posedge CLK) begin
    if (MemWrEn) sram[MemAddr] <= MemWrData;
    if (MemRdEn) MemRdData <= sram[MemAddr];
    if (rd2_en) rd2_data <= {16'hA5A5, addr2};
    if (MemRdEn) rd_cnt++;
    if (MemWrEn) wr_cnt++;
    if (IDataValid) iv_cnt++;
    if (DDataValid) dv_cnt++;
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic i_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int n;
    IMemRead = 1'b1;
    IMemReadAddr = a;
    n = 0;
    do begin tick; n++; end while (!IDataValid && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_data"}, IDataOut, exp);
    chk({tag, "_dvalid"}, 32'(DDataValid), 32'd0);
    IMemRead = 1'b0;
    tick;
  endtask
  task automatic d_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int n;
    DMemRead = 1'b1;
    DMemAddr = a;
    n = 0;
    do begin tick; n++; end while (!DDataValid && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'd3);
    chk({tag, "_data"}, DDataOut, exp);
    DMemRead = 1'b0;
    tick;
  endtask
  initial begin
    int rd0, n;
    logic exp_i;
    sram[16'h0010] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) sram[16'h0040 + i] = 32'hA000_0000 + 32'(i * 17);
    #2;
    chk("rst_ivalid", 32'(IDataValid), 32'd0);
    chk("rst_wren", 32'(MemWrEn), 32'd0);
    chk("rst_addr", 32'(MemAddr), 32'd0);
    tick;
    Reset_L = 1'b1;
    tick;
    // single I read, cycle by cycle
    IMemRead = 1'b1;
    IMemReadAddr = 32'h40;
    tick;
    chk("t1_c1_rden", 32'(MemRdEn), 32'd0);
    chk("t1_c1_addr", 32'(MemAddr), 32'd0);
    tick;
    chk("t1_c2_rden", 32'(MemRdEn), 32'd1);
    chk("t1_c2_addr", 32'(MemAddr), 32'h10);
    tick;
    chk("t1_c3_valid", 32'(IDataValid), 32'd1);
    chk("t1_c3_data", IDataOut, 32'hDEADBEEF);
    chk("t1_c3_rden", 32'(MemRdEn), 32'd0);
    IMemRead = 1'b0;
    tick;
    chk("t1_c4_valid", 32'(IDataValid), 32'd0);
    chk("t1_c4_data", IDataOut, 32'd0);
    // line fill
    rd0 = rd_cnt;
    for (int i = 0; i < 4; i++) i_read(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i * 17), "fill");
    chk("fill_accesses", 32'(rd_cnt - rd0), 32'd4);
    // D write then read back
    DMemWrite = 1'b1;
    DMemRead = 1'b1;
    DMemAddr = 32'h200;
    DMemWriteData = 32'h12345678;
    tick;
    DMemWriteData = 32'hFFFF_FFFF;
    chk("wr_c1_wren", 32'(MemWrEn), 32'd0);
    tick;
    chk("wr_c2_wren", 32'(MemWrEn), 32'd1);
    chk("wr_c2_rden", 32'(MemRdEn), 32'd0);
    chk("wr_c2_addr", 32'(MemAddr), 32'h80);
    chk("wr_c2_data", MemWrData, 32'h12345678);
    tick;
    chk("wr_ack", 32'(DDataValid), 32'd1);
    chk("wr_ack_data", DDataOut, 32'd0);
    chk("wr_ack_ivalid", 32'(IDataValid), 32'd0);
    DMemWrite = 1'b0;
    DMemRead = 1'b0;
    tick;
    chk("wr_count", 32'(wr_cnt), 32'd1);
    d_read(32'h200, 32'h12345678, "rdback");
    d_read(32'h40203, 32'h12345678, "alias");
    // tie: last grant was D, so I wins first
    IMemRead = 1'b1;
    IMemReadAddr = 32'h40;
    DMemRead = 1'b1;
    DMemAddr = 32'h200;
    exp_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin tick; n++; end while (!IDataValid && !DDataValid && n < 20);
      chk("tie_ivalid", 32'(IDataValid), 32'(exp_i));
      chk("tie_dvalid", 32'(DDataValid), 32'(!exp_i));
      chk("tie_data", exp_i ? IDataOut : DDataOut, exp_i ? 32'hDEADBEEF : 32'h12345678);
      exp_i = !exp_i;
    end
    IMemRead = 1'b0;
    DMemRead = 1'b0;
    tick;
    tick;
    // reset during ACCESS
    rd0 = rd_cnt;
    n = iv_cnt + dv_cnt;
    IMemRead = 1'b1;
    IMemReadAddr = 32'h40;
    tick;
    Reset_L = 1'b0;
    IMemRead = 1'b0;
    #1;
    chk("rstmid_rden", 32'(MemRdEn), 32'd0);
    chk("rstmid_state", 32'(u_dut.state), 32'd0);
    tick;
    tick;
    Reset_L = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    chk("rstmid_no_strobe", 32'(rd_cnt - rd0), 32'd0);
    chk("rstmid_no_valid", 32'(iv_cnt + dv_cnt - n), 32'd0);
    i_read(32'h40, 32'hDEADBEEF, "post_rst");
    // LATENCY=2 instance
    i2_rd = 1'b1;
    i2_addr = 32'h0003_1234;
    tick;
    chk("l2_c1_rden", 32'(rd2_en), 32'd1);
    chk("l2_c1_addr", 32'(addr2), 32'hC48D);
    tick;
    chk("l2_c2_valid", 32'(i2_valid), 32'd1);
    chk("l2_c2_data", i2_out, 32'hA5A5_C48D);
    i2_rd = 1'b0;
    tick;
    chk("l2_c3_valid", 32'(i2_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
